// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the alignment rule used both at accept time and by the lane logic.
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  // Illegal funct3 codes are reported as misaligned so they never reach the bus.
  function automatic logic lsu_misaligned(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    case (funct3)
      LSU_B, LSU_BU: lsu_misaligned = 1'b0;
      LSU_H, LSU_HU: lsu_misaligned = addr_lo[0];
      LSU_W:         lsu_misaligned = |addr_lo;
      default:       lsu_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store strobes and replicated
// write data, load lane selection with sign/zero extension, misalign flag.
import lsu_pkg::*;

module lsu_align (
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [31:0] lane_word;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    misalign_o = lsu_misaligned(funct3_i, addr_lo_i);
    be_o       = 4'b1111;
    wdata_o    = wdata_i;
    if (we_i) begin
      case (funct3_i)
        LSU_B: begin
          be_o    = 4'b0001 << addr_lo_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        LSU_H: begin
          be_o    = 4'b0011 << addr_lo_i;
          wdata_o = {2{wdata_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Shifting the addressed lane down to bit 0 serves bytes and halfwords alike.
  always_comb begin
    lane_word = mem_word_i >> {addr_lo_i, 3'b000};
    lane_byte = lane_word[7:0];
    lane_half = lane_word[15:0];
    case (funct3_i)
      LSU_B:   rdata_o = {{24{lane_byte[7]}}, lane_byte};
      LSU_BU:  rdata_o = {24'h0, lane_byte};
      LSU_H:   rdata_o = {{16{lane_half[15]}}, lane_half};
      LSU_HU:  rdata_o = {16'h0, lane_half};
      LSU_W:   rdata_o = mem_word_i;
      default: rdata_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: latches the access on accept, runs a req/gnt/rvalid
// transaction and returns the extended load result in a one-cycle DONE.
import lsu_pkg::*;

module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              we_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              misalign_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i
);

  lsu_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rword_q, rword_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        lane_misalign;
  logic        in_req;
  logic        in_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      rword_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rword_q  <= rword_d;
    end
  end

  // Only IDLE samples start_i; responses outside their own state are ignored.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rword_d  = rword_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          we_d     = we_i;
          funct3_d = funct3_i;
          addr_d   = addr_i;
          wdata_d  = wdata_i;
          state_d  = lsu_misaligned(funct3_i, addr_i[1:0]) ? DONE : REQ;
        end
      end
      REQ: begin
        if (mem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          rword_d = mem_rdata_i;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  lsu_align u_align (
    .we_i       (we_q),
    .funct3_i   (funct3_q),
    .addr_lo_i  (addr_q[1:0]),
    .wdata_i    (wdata_q),
    .mem_word_i (rword_q),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .rdata_o    (lane_rdata),
    .misalign_o (lane_misalign)
  );

  // Bus outputs come from latched state only, so gnt never feeds back into req.
  always_comb begin
    in_req      = (state_q == REQ);
    in_done     = (state_q == DONE);
    mem_req_o   = in_req;
    mem_we_o    = in_req & we_q;
    mem_addr_o  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem_be_o    = in_req ? lane_be : 4'b0000;
    mem_wdata_o = (in_req & we_q) ? lane_wdata : 32'h0;
    done_o      = in_done;
    misalign_o  = in_done & lane_misalign;
    rdata_o     = (in_done & ~we_q & ~lane_misalign) ? lane_rdata : 32'h0;
    stall_o     = rst_n & (((state_q == IDLE) & start_i) | in_req | (state_q == WAIT));
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, self-checking bench for load_store_unit: each task drives one
// scenario cycle by cycle and compares outputs against hand-computed values.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        misalign_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int n_cmp  = 0;
  int n_fail = 0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .we_i         (we_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .rdata_o      (rdata_o),
    .misalign_o   (misalign_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; we_i = 1'b0; funct3_i = 3'b000;
    addr_i = 32'h0; wdata_i = 32'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    @(negedge clk); @(negedge clk); #1;
    n_cmp++;
    if ({stall_o, done_o, misalign_o, mem_req_o, mem_we_o} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 00000", {stall_o, done_o, misalign_o, mem_req_o, mem_we_o});
    end
    n_cmp++;
    if ({rdata_o, mem_addr_o, mem_wdata_o, mem_be_o} !== 100'h0) begin
      n_fail++; $display("FAIL reset_data got rdata=%h addr=%h wdata=%h be=%b want all zero", rdata_o, mem_addr_o, mem_wdata_o, mem_be_o);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_lb();
    @(negedge clk); start_i = 1'b1; we_i = 1'b0; funct3_i = 3'b000; addr_i = 32'h1003; #1;
    n_cmp++;
    if ({stall_o, mem_req_o} !== 2'b10) begin
      n_fail++; $display("FAIL lb_c0 stall/req got %b want 10", {stall_o, mem_req_o});
    end
    @(negedge clk); start_i = 1'b0; mem_gnt_i = 1'b1; #1;
    n_cmp++;
    if ({stall_o, mem_req_o, mem_we_o, mem_be_o} !== 7'b1101111) begin
      n_fail++; $display("FAIL lb_c1 stall/req/we/be got %b want 1101111", {stall_o, mem_req_o, mem_we_o, mem_be_o});
    end
    n_cmp++;
    if (mem_addr_o !== 32'h0000_1000) begin
      n_fail++; $display("FAIL lb_addr got %h want 00001000", mem_addr_o);
    end
    @(negedge clk); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h80FF_1234; #1;
    n_cmp++;
    if ({stall_o, mem_req_o, done_o} !== 3'b100) begin
      n_fail++; $display("FAIL lb_c2 stall/req/done got %b want 100", {stall_o, mem_req_o, done_o});
    end
    @(negedge clk); mem_rvalid_i = 1'b0; #1;
    n_cmp++;
    if ({done_o, stall_o, misalign_o} !== 3'b100) begin
      n_fail++; $display("FAIL lb_c3 done/stall/misalign got %b want 100", {done_o, stall_o, misalign_o});
    end
    n_cmp++;
    if (rdata_o !== 32'hFFFF_FF80) begin
      n_fail++; $display("FAIL lb_rdata got %h want ffffff80", rdata_o);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({done_o, rdata_o} !== 33'h0) begin
      n_fail++; $display("FAIL lb_after done=%b rdata=%h want 0/0", done_o, rdata_o);
    end
  endtask

  task automatic test_load_lanes();
    logic [2:0]  f3 [7]  = '{3'b100, 3'b000, 3'b000, 3'b001, 3'b001, 3'b010, 3'b101};
    logic [31:0] ad [7]  = '{32'h1003, 32'h1001, 32'h1002, 32'h1000, 32'h1002, 32'h1000, 32'h1002};
    logic [31:0] exp [7] = '{32'h0000_0080, 32'h0000_0012, 32'hFFFF_FFFF, 32'h0000_1234,
                             32'hFFFF_80FF, 32'h80FF_1234, 32'h0000_80FF};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); start_i = 1'b1; we_i = 1'b0; funct3_i = f3[i]; addr_i = ad[i];
      @(negedge clk); start_i = 1'b0; mem_gnt_i = 1'b1;
      @(negedge clk); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h80FF_1234;
      @(negedge clk); mem_rvalid_i = 1'b0; #1;
      n_cmp++;
      if (done_o !== 1'b1 || rdata_o !== exp[i]) begin
        n_fail++; $display("FAIL load_lane[%0d] done=%b rdata=%h want 1/%h", i, done_o, rdata_o, exp[i]);
      end
    end
  endtask

  task automatic test_lhu_gnt_delay();
    @(negedge clk); start_i = 1'b1; we_i = 1'b0; funct3_i = 3'b101; addr_i = 32'h2002;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); start_i = 1'b0; #1;
      n_cmp++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_2000 || stall_o !== 1'b1) begin
        n_fail++; $display("FAIL lhu_hold c%0d req=%b addr=%h stall=%b want 1/00002000/1", c, mem_req_o, mem_addr_o, stall_o);
      end
    end
    // rvalid together with gnt is illegal and must be ignored
    @(negedge clk); mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF; #1;
    n_cmp++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_2000) begin
      n_fail++; $display("FAIL lhu_c4 req=%b addr=%h want 1/00002000", mem_req_o, mem_addr_o);
    end
    @(negedge clk); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h8001_0000; #1;
    n_cmp++;
    if ({stall_o, done_o, mem_req_o} !== 3'b100) begin
      n_fail++; $display("FAIL lhu_c5 stall/done/req got %b want 100", {stall_o, done_o, mem_req_o});
    end
    @(negedge clk); mem_rvalid_i = 1'b0; #1;
    n_cmp++;
    if (done_o !== 1'b1 || rdata_o !== 32'h0000_8001) begin
      n_fail++; $display("FAIL lhu_c6 done=%b rdata=%h want 1/00008001", done_o, rdata_o);
    end
  endtask

  task automatic test_stores();
    logic [2:0]  f3 [4] = '{3'b000, 3'b001, 3'b010, 3'b000};
    logic [31:0] ad [4] = '{32'h3001, 32'h3002, 32'h3000, 32'h3003};
    logic [31:0] wd [4] = '{32'h0000_00AB, 32'h1234_CDEF, 32'hCAFE_F00D, 32'h0000_0077};
    logic [3:0]  eb [4] = '{4'b0010, 4'b1100, 4'b1111, 4'b1000};
    logic [31:0] ew [4] = '{32'hABAB_ABAB, 32'hCDEF_CDEF, 32'hCAFE_F00D, 32'h7777_7777};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); start_i = 1'b1; we_i = 1'b1; funct3_i = f3[i]; addr_i = ad[i]; wdata_i = wd[i];
      @(negedge clk); start_i = 1'b0; mem_gnt_i = 1'b1; #1;
      n_cmp++;
      if ({mem_req_o, mem_we_o, mem_be_o} !== {2'b11, eb[i]} || mem_wdata_o !== ew[i] || mem_addr_o !== 32'h0000_3000) begin
        n_fail++; $display("FAIL store[%0d] req=%b we=%b be=%b wdata=%h addr=%h want 1/1/%b/%h/00003000",
                           i, mem_req_o, mem_we_o, mem_be_o, mem_wdata_o, mem_addr_o, eb[i], ew[i]);
      end
      @(negedge clk); mem_gnt_i = 1'b0; #1;
      n_cmp++;
      if ({stall_o, done_o} !== 2'b10) begin
        n_fail++; $display("FAIL store_wait[%0d] stall/done got %b want 10", i, {stall_o, done_o});
      end
      @(negedge clk); mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
      @(negedge clk); mem_rvalid_i = 1'b0; #1;
      n_cmp++;
      if (done_o !== 1'b1 || rdata_o !== 32'h0 || misalign_o !== 1'b0) begin
        n_fail++; $display("FAIL store_done[%0d] done=%b rdata=%h misalign=%b want 1/00000000/0", i, done_o, rdata_o, misalign_o);
      end
    end
    we_i = 1'b0; wdata_i = 32'h0;
  endtask

  task automatic test_misaligned();
    logic        wv [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  f3 [3] = '{3'b010, 3'b001, 3'b011};
    logic [31:0] ad [3] = '{32'h4002, 32'h4001, 32'h4000};
    mem_rdata_i = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); start_i = 1'b1; we_i = wv[i]; funct3_i = f3[i]; addr_i = ad[i]; wdata_i = 32'h1234_5678; #1;
      n_cmp++;
      if ({stall_o, mem_req_o} !== 2'b10) begin
        n_fail++; $display("FAIL mis_c0[%0d] stall/req got %b want 10", i, {stall_o, mem_req_o});
      end
      @(negedge clk); start_i = 1'b0; #1;
      n_cmp++;
      if ({done_o, misalign_o, mem_req_o, stall_o} !== 4'b1100 || rdata_o !== 32'h0) begin
        n_fail++; $display("FAIL mis_c1[%0d] done/mis/req/stall=%b rdata=%h want 1100/00000000",
                           i, {done_o, misalign_o, mem_req_o, stall_o}, rdata_o);
      end
      @(negedge clk); #1;
      n_cmp++;
      if ({done_o, misalign_o, mem_req_o} !== 3'b000) begin
        n_fail++; $display("FAIL mis_c2[%0d] done/mis/req got %b want 000", i, {done_o, misalign_o, mem_req_o});
      end
    end
    we_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk); start_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h5000;
    @(negedge clk); start_i = 1'b0; mem_gnt_i = 1'b1;
    @(negedge clk); mem_gnt_i = 1'b0; #1;
    n_cmp++;
    if (stall_o !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre stall got %b want 1", stall_o);
    end
    rst_n = 1'b0; #1;
    n_cmp++;
    if ({stall_o, done_o, misalign_o, mem_req_o, mem_we_o} !== 5'b0 ||
        {rdata_o, mem_addr_o, mem_wdata_o, mem_be_o} !== 100'h0) begin
      n_fail++; $display("FAIL rstmid_outputs ctrl=%b rdata=%h addr=%h wdata=%h be=%b want all zero",
                         {stall_o, done_o, misalign_o, mem_req_o, mem_we_o}, rdata_o, mem_addr_o, mem_wdata_o, mem_be_o);
    end
    @(negedge clk); rst_n = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678; #1;
    n_cmp++;
    if ({done_o, stall_o} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_stray done/stall got %b want 00", {done_o, stall_o});
    end
    @(negedge clk); mem_rvalid_i = 1'b0; #1;
    n_cmp++;
    if ({done_o, stall_o, rdata_o} !== 34'h0) begin
      n_fail++; $display("FAIL rstmid_after done=%b stall=%b rdata=%h want 0/0/0", done_o, stall_o, rdata_o);
    end
    @(negedge clk); start_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h0;
    @(negedge clk); start_i = 1'b0; mem_gnt_i = 1'b1; #1;
    n_cmp++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_fresh_req req=%b addr=%h want 1/00000000", mem_req_o, mem_addr_o);
    end
    @(negedge clk); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1122_3344;
    @(negedge clk); mem_rvalid_i = 1'b0; #1;
    n_cmp++;
    if (done_o !== 1'b1 || rdata_o !== 32'h1122_3344 || misalign_o !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_fresh_done done=%b rdata=%h mis=%b want 1/11223344/0", done_o, rdata_o, misalign_o);
    end
  endtask

  task automatic test_start_held();
    int n_req = 0;
    @(negedge clk); start_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0;
    @(negedge clk); mem_gnt_i = 1'b1; #1; n_req += int'(mem_req_o);
    @(negedge clk); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA5A5_A5A5; #1; n_req += int'(mem_req_o);
    @(negedge clk); mem_rvalid_i = 1'b0; #1; n_req += int'(mem_req_o);
    n_cmp++;
    if ({done_o, stall_o} !== 2'b10 || rdata_o !== 32'hA5A5_A5A5) begin
      n_fail++; $display("FAIL held_done done/stall=%b rdata=%h want 10/a5a5a5a5", {done_o, stall_o}, rdata_o);
    end
    @(negedge clk); #1; n_req += int'(mem_req_o);
    n_cmp++;
    if ({done_o, stall_o} !== 2'b01) begin
      n_fail++; $display("FAIL held_idle done/stall got %b want 01", {done_o, stall_o});
    end
    n_cmp++;
    if (n_req !== 1) begin
      n_fail++; $display("FAIL held_txn_count got %0d want 1", n_req);
    end
    @(negedge clk); start_i = 1'b0; mem_gnt_i = 1'b1; #1;
    n_cmp++;
    if (mem_req_o !== 1'b1) begin
      n_fail++; $display("FAIL held_reaccept req got %b want 1", mem_req_o);
    end
    @(negedge clk); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5A5A_5A5A;
    @(negedge clk); mem_rvalid_i = 1'b0; #1;
    n_cmp++;
    if (done_o !== 1'b1 || rdata_o !== 32'h5A5A_5A5A) begin
      n_fail++; $display("FAIL held_second done=%b rdata=%h want 1/5a5a5a5a", done_o, rdata_o);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lb();
    test_load_lanes();
    test_lhu_gnt_delay();
    test_stores();
    test_misaligned();
    test_reset_mid();
    test_start_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
